// File: rtl/joybus_poll_sched.sv
// Poll sequencer and host arbiter for the shared JOYBUS transmitter.
// Owns the cmd_rdy handshake, tracks TX/RX timeouts and enforces a bus turnaround gap.
module joybus_poll_sched #(
    parameter int POLL_PERIOD = 416667,
    parameter int RX_TIMEOUT  = 2500,
    parameter int TX_TIMEOUT  = 50000,
    parameter int GAP_CYC     = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_req,
    input  logic [7:0] host_cmd,
    output logic       host_ack,
    output logic       host_done,
    output logic       host_to,
    output logic [7:0] cmd_data,
    output logic       cmd_rdy,
    input  logic       tx_done,
    input  logic       rx_done,
    output logic       ctrl_present,
    output logic       poll_done,
    output logic       busy,
    output logic [7:0] err_cnt
);

    localparam int PW    = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
    localparam int TMAX0 = (TX_TIMEOUT > RX_TIMEOUT) ? TX_TIMEOUT : RX_TIMEOUT;
    localparam int TMAX  = (TMAX0 > GAP_CYC) ? TMAX0 : GAP_CYC;
    localparam int TW    = (TMAX > 2) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_TX = 3'd2,
        S_WAIT_RX = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t        state_r, state_nxt_s;
    logic [PW-1:0] poll_tmr_r, poll_tmr_nxt_s;
    logic          poll_pend_r, poll_pend_nxt_s;
    logic [TW-1:0] tmr_r, tmr_nxt_s;
    logic          owner_host_r, owner_host_nxt_s;
    logic [7:0]    cmd_lat_r, cmd_lat_nxt_s;
    logic [7:0]    cmd_data_r, cmd_data_nxt_s;
    logic          cmd_rdy_r, cmd_rdy_nxt_s;
    logic          host_ack_r, host_ack_nxt_s;
    logic          host_done_r, host_done_nxt_s;
    logic          host_to_r, host_to_nxt_s;
    logic          poll_done_r, poll_done_nxt_s;
    logic          ctrl_present_r, ctrl_present_nxt_s;
    logic          busy_r, busy_nxt_s;
    logic [7:0]    err_cnt_r, err_cnt_nxt_s;

    logic poll_wrap_s, poll_issue_s, end_ok_s, end_to_s, txn_end_s;

    // A real tx_done/rx_done beats a timeout landing on the same cycle.
    assign poll_wrap_s = (poll_tmr_r == PW'(POLL_PERIOD - 1));
    assign end_ok_s    = (state_r == S_WAIT_RX) && rx_done;
    assign end_to_s    = ((state_r == S_WAIT_TX) && !tx_done && (tmr_r == TW'(TX_TIMEOUT - 1))) ||
                         ((state_r == S_WAIT_RX) && !rx_done && (tmr_r == TW'(RX_TIMEOUT - 1)));
    assign txn_end_s   = end_ok_s || end_to_s;

    // Next-state, counters and next output values.
    always_comb begin
        state_nxt_s      = state_r;
        tmr_nxt_s        = tmr_r + TW'(1);
        owner_host_nxt_s = owner_host_r;
        cmd_lat_nxt_s    = cmd_lat_r;
        cmd_data_nxt_s   = cmd_data_r;
        cmd_rdy_nxt_s    = 1'b0;
        host_ack_nxt_s   = 1'b0;
        poll_issue_s     = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (host_req) begin
                    host_ack_nxt_s   = 1'b1;
                    owner_host_nxt_s = 1'b1;
                    state_nxt_s      = S_ISSUE;
                end else if (poll_pend_r) begin
                    owner_host_nxt_s = 1'b0;
                    cmd_lat_nxt_s    = ctrl_present_r ? 8'h01 : 8'h00;
                    poll_issue_s     = 1'b1;
                    state_nxt_s      = S_ISSUE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                // host_cmd is taken while host_ack is visible, i.e. this cycle.
                cmd_rdy_nxt_s  = 1'b1;
                cmd_data_nxt_s = owner_host_r ? host_cmd : cmd_lat_r;
                tmr_nxt_s      = {TW{1'b0}};
                state_nxt_s    = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_done) begin
                    tmr_nxt_s   = {TW{1'b0}};
                    state_nxt_s = S_WAIT_RX;
                end else if (end_to_s) begin
                    tmr_nxt_s   = {TW{1'b0}};
                    state_nxt_s = S_GAP;
                end else begin
                    state_nxt_s = S_WAIT_TX;
                end
            end
            S_WAIT_RX: begin
                if (txn_end_s) begin
                    tmr_nxt_s   = {TW{1'b0}};
                    state_nxt_s = S_GAP;
                end else begin
                    state_nxt_s = S_WAIT_RX;
                end
            end
            S_GAP: begin
                if (tmr_r == TW'(GAP_CYC - 1)) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_GAP;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase

        host_done_nxt_s    = txn_end_s && owner_host_r;
        host_to_nxt_s      = (txn_end_s && owner_host_r) ? end_to_s : host_to_r;
        poll_done_nxt_s    = end_ok_s && !owner_host_r;
        ctrl_present_nxt_s = (txn_end_s && !owner_host_r) ? end_ok_s : ctrl_present_r;
        err_cnt_nxt_s      = end_to_s ? sat_inc8(err_cnt_r) : err_cnt_r;
        busy_nxt_s         = (state_nxt_s != S_IDLE);

        poll_tmr_nxt_s  = poll_wrap_s ? {PW{1'b0}} : poll_tmr_r + PW'(1);
        // Wraps while already pending collapse into one request.
        poll_pend_nxt_s = poll_wrap_s ? 1'b1 : (poll_issue_s ? 1'b0 : poll_pend_r);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= S_IDLE;
            poll_tmr_r     <= {PW{1'b0}};
            poll_pend_r    <= 1'b1;
            tmr_r          <= {TW{1'b0}};
            owner_host_r   <= 1'b0;
            cmd_lat_r      <= 8'h00;
            cmd_data_r     <= 8'h00;
            cmd_rdy_r      <= 1'b0;
            host_ack_r     <= 1'b0;
            host_done_r    <= 1'b0;
            host_to_r      <= 1'b0;
            poll_done_r    <= 1'b0;
            ctrl_present_r <= 1'b0;
            busy_r         <= 1'b0;
            err_cnt_r      <= 8'h00;
        end else begin
            state_r        <= state_nxt_s;
            poll_tmr_r     <= poll_tmr_nxt_s;
            poll_pend_r    <= poll_pend_nxt_s;
            tmr_r          <= tmr_nxt_s;
            owner_host_r   <= owner_host_nxt_s;
            cmd_lat_r      <= cmd_lat_nxt_s;
            cmd_data_r     <= cmd_data_nxt_s;
            cmd_rdy_r      <= cmd_rdy_nxt_s;
            host_ack_r     <= host_ack_nxt_s;
            host_done_r    <= host_done_nxt_s;
            host_to_r      <= host_to_nxt_s;
            poll_done_r    <= poll_done_nxt_s;
            ctrl_present_r <= ctrl_present_nxt_s;
            busy_r         <= busy_nxt_s;
            err_cnt_r      <= err_cnt_nxt_s;
        end
    end

    assign host_ack     = host_ack_r;
    assign host_done    = host_done_r;
    assign host_to      = host_to_r;
    assign cmd_data     = cmd_data_r;
    assign cmd_rdy      = cmd_rdy_r;
    assign ctrl_present = ctrl_present_r;
    assign poll_done    = poll_done_r;
    assign busy         = busy_r;
    assign err_cnt      = err_cnt_r;

endmodule

// File: tb/tb_joybus_poll_sched.sv
// Bench for joybus_poll_sched: host command table, poll/reset sequences and a
// second short-period instance for error-counter saturation.
module tb_joybus_poll_sched;

    localparam int POLL_P = 1000;
    localparam int TX_TO  = 50;
    localparam int RX_TO  = 20;
    localparam int GAP    = 4;

    logic       clk = 1'b0;
    logic       rst, host_req, tx_done, rx_done;
    logic [7:0] host_cmd;
    logic       host_ack, host_done, host_to, cmd_rdy, ctrl_present, poll_done, busy;
    logic [7:0] cmd_data, err_cnt;

    logic       rst_sat, sat_host_req, sat_tx_done, sat_rx_done;
    logic [7:0] sat_host_cmd;
    logic       sat_host_ack, sat_host_done, sat_host_to, sat_cmd_rdy, sat_ctrl_present, sat_poll_done, sat_busy;
    logic [7:0] sat_cmd_data, sat_err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_err;
    logic [7:0] exp_cmd_q[$];
    logic       exp_hto_q[$];
    logic [7:0] exp_c;
    logic       exp_h;

    typedef struct {
        logic [7:0] cmd;
        int         tx_dly;   // -1: tx_done never arrives
        int         rx_dly;   // -1: rx_done never arrives
        logic       exp_to;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    joybus_poll_sched #(.POLL_PERIOD(POLL_P), .RX_TIMEOUT(RX_TO), .TX_TIMEOUT(TX_TO), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst(rst), .host_req(host_req), .host_cmd(host_cmd), .host_ack(host_ack),
        .host_done(host_done), .host_to(host_to), .cmd_data(cmd_data), .cmd_rdy(cmd_rdy),
        .tx_done(tx_done), .rx_done(rx_done), .ctrl_present(ctrl_present), .poll_done(poll_done),
        .busy(busy), .err_cnt(err_cnt)
    );

    joybus_poll_sched #(.POLL_PERIOD(60), .RX_TIMEOUT(RX_TO), .TX_TIMEOUT(TX_TO), .GAP_CYC(GAP)) dut_sat (
        .clk(clk), .rst(rst_sat), .host_req(sat_host_req), .host_cmd(sat_host_cmd), .host_ack(sat_host_ack),
        .host_done(sat_host_done), .host_to(sat_host_to), .cmd_data(sat_cmd_data), .cmd_rdy(sat_cmd_rdy),
        .tx_done(sat_tx_done), .rx_done(sat_rx_done), .ctrl_present(sat_ctrl_present), .poll_done(sat_poll_done),
        .busy(sat_busy), .err_cnt(sat_err_cnt)
    );

    // Cycle index since the main instance left reset.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cmd(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            if (cmd_rdy === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_cmd_rdy: no cmd_rdy within %0d cycles", budget);
        end
    endtask

    task automatic pulse_tx(input int dly);
        step(dly - 1);
        tx_done = 1'b1;
        step(1);
        tx_done = 1'b0;
    endtask

    task automatic pulse_rx(input int dly);
        step(dly - 1);
        rx_done = 1'b1;
        step(1);
        rx_done = 1'b0;
    endtask

    // Scoreboard: commands and host results are compared as the DUT emits them.
    always @(negedge clk) begin
        if (cmd_rdy === 1'b1) begin
            if (exp_cmd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_cmd: unexpected cmd_rdy with data %0h", cmd_data);
            end else begin
                exp_c = exp_cmd_q.pop_front();
                chk("sb_cmd_data", {24'd0, cmd_data}, {24'd0, exp_c});
            end
        end
        if (host_done === 1'b1) begin
            if (exp_hto_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_host_done: unexpected host_done, host_to %0b", host_to);
            end else begin
                exp_h = exp_hto_q.pop_front();
                chk("sb_host_to", {31'd0, host_to}, {31'd0, exp_h});
            end
        end
    end

    task automatic run_host(input vec_t v);
        host_req = 1'b1;
        host_cmd = v.cmd;
        exp_cmd_q.push_back(v.cmd);
        exp_hto_q.push_back(v.exp_to);
        step(1);
        chk("host_ack", {31'd0, host_ack}, 32'd1);
        host_req = 1'b0;
        step(1);
        chk("host_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        chk("host_ack_pulse", {31'd0, host_ack}, 32'd0);
        host_cmd = ~v.cmd;
        if (v.tx_dly < 0) begin
            step(TX_TO - 1);
            chk("tx_to_early", {24'd0, err_cnt}, exp_err);
            step(1);
        end else begin
            pulse_tx(v.tx_dly);
            if (v.rx_dly < 0) begin
                step(RX_TO - 1);
                chk("rx_to_early", {24'd0, err_cnt}, exp_err);
                step(1);
            end else begin
                pulse_rx(v.rx_dly);
            end
        end
        if (v.exp_to && exp_err < 255) exp_err++;
        chk("host_done", {31'd0, host_done}, 32'd1);
        chk("host_err_cnt", {24'd0, err_cnt}, exp_err);
        chk("host_ctrl_hold", {31'd0, ctrl_present}, 32'd1);
        // A stray rx_done inside the gap must be ignored.
        rx_done = 1'b1;
        step(1);
        rx_done = 1'b0;
        chk("host_done_pulse", {31'd0, host_done}, 32'd0);
        step(2);
        chk("gap_busy", {31'd0, busy}, 32'd1);
        step(1);
        chk("gap_end_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int d;
        int n;
        vecs[0] = '{8'h40,  3, 10, 1'b0};
        vecs[1] = '{8'hA5, -1, -1, 1'b1};
        vecs[2] = '{8'h3C, 50,  5, 1'b0};
        vecs[3] = '{8'h81,  2, 20, 1'b0};
        vecs[4] = '{8'h02,  4, -1, 1'b1};
        vecs[5] = '{8'h00,  1,  1, 1'b0};

        rst = 1'b1; rst_sat = 1'b1;
        host_req = 1'b0; host_cmd = 8'h00; tx_done = 1'b0; rx_done = 1'b0;
        sat_host_req = 1'b0; sat_host_cmd = 8'h00; sat_tx_done = 1'b0; sat_rx_done = 1'b0;
        exp_err = 0;
        step(3);
        chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        chk("rst_cmd_data", {24'd0, cmd_data}, 32'h00);
        chk("rst_ctrl", {31'd0, ctrl_present}, 32'd0);
        chk("rst_err", {24'd0, err_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pulses", {29'd0, host_ack, host_done, poll_done}, 32'd0);

        // First INFO poll right after reset, never answered.
        exp_cmd_q.push_back(8'h00);
        rst = 1'b0;
        step(1);
        chk("poll0_no_rdy_yet", {31'd0, cmd_rdy}, 32'd0);
        chk("poll0_busy", {31'd0, busy}, 32'd1);
        step(1);
        chk("poll0_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        step(2);
        tx_done = 1'b1;
        step(1);
        tx_done = 1'b0;
        step(RX_TO - 1);
        chk("poll0_err_before", {24'd0, err_cnt}, 32'd0);
        step(1);
        exp_err = 1;
        chk("poll0_err", {24'd0, err_cnt}, exp_err);
        chk("poll0_ctrl", {31'd0, ctrl_present}, 32'd0);
        chk("poll0_no_done", {31'd0, poll_done}, 32'd0);
        step(GAP);
        chk("poll0_idle", {31'd0, busy}, 32'd0);

        // INFO answered on the next period.
        exp_cmd_q.push_back(8'h00);
        wait_cmd(POLL_P + 200);
        chk("poll1_period", cyc, POLL_P + 2);
        pulse_tx(2);
        pulse_rx(10);
        chk("poll1_done", {31'd0, poll_done}, 32'd1);
        chk("poll1_ctrl", {31'd0, ctrl_present}, 32'd1);
        chk("poll1_err", {24'd0, err_cnt}, exp_err);
        step(1);
        chk("poll1_done_pulse", {31'd0, poll_done}, 32'd0);
        step(GAP);

        // Controller now present: STATUS poll.
        exp_cmd_q.push_back(8'h01);
        wait_cmd(POLL_P + 200);
        chk("poll2_period", cyc, 2 * POLL_P + 2);
        pulse_tx(1);
        pulse_rx(1);
        chk("poll2_done", {31'd0, poll_done}, 32'd1);
        step(GAP + 1);

        for (int i = 0; i < 6; i++) run_host(vecs[i]);

        // Host request on the exact poll-timer wrap cycle.
        if (cyc < 3 * POLL_P - 1) step(3 * POLL_P - 1 - cyc);
        host_req = 1'b1;
        host_cmd = 8'hFF;
        exp_cmd_q.push_back(8'hFF);
        exp_hto_q.push_back(1'b0);
        step(1);
        chk("tie_host_ack", {31'd0, host_ack}, 32'd1);
        host_req = 1'b0;
        exp_cmd_q.push_back(8'h01);
        step(1);
        chk("tie_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        pulse_tx(3);
        pulse_rx(4);
        chk("tie_host_done", {31'd0, host_done}, 32'd1);
        d = cyc;
        wait_cmd(40);
        chk("tie_poll_after_gap", cyc - d, GAP + 2);
        pulse_tx(1);
        pulse_rx(1);
        chk("tie_poll_done", {31'd0, poll_done}, 32'd1);
        step(GAP + 1);

        // Reset in the middle of WAIT_RX.
        exp_cmd_q.push_back(8'h01);
        wait_cmd(POLL_P + 200);
        pulse_tx(2);
        step(3);
        rst = 1'b1;
        step(1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_pulses", {30'd0, host_done, poll_done}, 32'd0);
        chk("midrst_ctrl", {31'd0, ctrl_present}, 32'd0);
        chk("midrst_err", {24'd0, err_cnt}, 32'd0);
        chk("midrst_cmd_data", {24'd0, cmd_data}, 32'h00);
        exp_cmd_q.push_back(8'h00);
        rst = 1'b0;
        step(2);
        chk("midrst_poll_rdy", {31'd0, cmd_rdy}, 32'd1);
        chk("midrst_poll_ctrl", {31'd0, ctrl_present}, 32'd0);
        pulse_tx(1);
        pulse_rx(1);
        chk("midrst_poll_done", {31'd0, poll_done}, 32'd1);
        step(GAP + 1);
        rst = 1'b1;

        // Saturation: short-period instance times out every poll.
        rst_sat = 1'b0;
        n = 0;
        for (int i = 0; i < 20000 && n < 261; i++) begin
            step(1);
            if (sat_cmd_rdy === 1'b1) begin
                n++;
                if (n == 11) chk("sat_err_10", {24'd0, sat_err_cnt}, 32'd10);
                if (n == 261) begin
                    chk("sat_err_255", {24'd0, sat_err_cnt}, 32'd255);
                    chk("sat_cmd_data", {24'd0, sat_cmd_data}, 32'h00);
                    chk("sat_ctrl", {31'd0, sat_ctrl_present}, 32'd0);
                end
            end
        end
        if (n < 261) begin
            checks++;
            errors++;
            $display("FAIL sat_polls: only %0d polls seen, need 261", n);
        end

        chk("sb_cmd_left", exp_cmd_q.size(), 32'd0);
        chk("sb_hto_left", exp_hto_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
